dvs_aer_event_rx: RTL and testbench
===================================

Name: dvs_aer_event_rx

Overview:
Parametrised next-generation DVS AER receiver. Performs the 4-phase REQ/ACK handshake with the camera and applies per-address-type setup delays. Pairs each row (Y) word with the column (X) words that follow it into complete events. Events go out on a one-entry valid/ready port; when downstream is full, the block stalls the camera by withholding ACK. Sits between the camera pins and the event FIFO/RAVENS interface.

Parameters:
ADDR_W, 10, width of AER address bus
SYNC_STAGES, 2, synchronizer depth for aer/xsel/req (>=2)
SETUP_Y, 3, clk cycles between synced REQ and sampling a Y word
SETUP_X, 0, clk cycles between synced REQ and sampling an X word
TIMEOUT, 64, max cycles in ACK state waiting for REQ low; 0 = disabled

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
en  in  1  1 = accept new handshakes; sampled only in IDLE
aer  in  ADDR_W  async AER address from camera
xsel  in  1  async; 1 = X word, 0 = Y word
req  in  1  async camera request
ack  out  1  registered acknowledge to camera
evt_valid  out  1  event available
evt_ready  in  1  downstream accepts event
evt_y  out  ADDR_W  row of event
evt_x  out  ADDR_W  column word of event (raw, polarity bits untouched)
orphan_x  out  1  1-cycle pulse: X word received with no stored Y
timeout_err  out  1  1-cycle pulse: REQ stayed high past TIMEOUT
busy  out  1  state != IDLE

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All logic on posedge clk.
- Reset values: ack=0, evt_valid=0, evt_y=0, evt_x=0, orphan_x=0, timeout_err=0, busy=0, y_valid=0, all sync stages=0, state=IDLE.
- aer, xsel and req each pass through SYNC_STAGES flops; the FSM uses only the synced copies (aer_s, xsel_s, req_s).
- States:
  - IDLE: if en && req_s: setup = xsel_s ? SETUP_X : SETUP_Y. If setup == 0, go to CAPTURE; else go to SETUP with cnt = setup-1.
  - SETUP: cnt==0 -> CAPTURE, else cnt--. Occupies exactly setup cycles.
  - CAPTURE, Y word (xsel_s=0): y_reg <= aer_s, y_valid <= 1, go to ACK.
  - CAPTURE, X word with y_valid=0: pulse orphan_x, discard word, go to ACK.
  - CAPTURE, X word with y_valid=1 and slot free (!evt_valid || evt_ready): evt_y <= y_reg, evt_x <= aer_s, evt_valid <= 1, go to ACK.
  - CAPTURE, X word with y_valid=1 and slot full: stay in CAPTURE (stall, ack=0) and resample aer_s each cycle.
  - ACK: ack=1. req_s==0 -> IDLE. Timeout counter increments each ACK cycle; when it reaches TIMEOUT (TIMEOUT>0), pulse timeout_err and go to RECOVER.
  - RECOVER: ack=0; req_s==0 -> IDLE. Prevents re-capture of a stuck REQ.
- ack is a flop set on the transition into ACK and cleared on exit; it must never glitch.
- Latency, with req driven just after an edge: ack rises at edge SYNC_STAGES+2+setup counted from the req edge (7 for Y, 4 for X at defaults).
- y_valid persists across X words so one Y serves a row burst. A new Y overwrites y_reg. Only reset clears y_valid.
- Output port: evt_valid stays high and evt_y/evt_x stay stable until evt_valid && evt_ready. Load and accept in the same cycle is allowed (back-to-back). With no new load, an accept clears evt_valid next edge.
- en deasserted mid-handshake does not abort; the handshake in progress completes.
- Timeout counter width is $clog2(TIMEOUT+1); it clears on every ACK entry.
- Reset asserted mid-operation immediately forces the reset values (ack drops asynchronously); any pending event and stored Y are lost.

Decomposition:
- dvs_ravens_pkg gains: typedef enum aer_rx_state_t {IDLE, SETUP, CAPTURE, ACK, RECOVER}; default constants AER_ADDR_W=10, AER_SYNC_STAGES=2, AER_SETUP_Y derived from 50ns/CLK_PERIOD minus 2 (floor 0), AER_TIMEOUT=64.
- Sub-module dvs_sync_bus #(WIDTH, STAGES): N-flop async-reset synchronizer, instantiated once for {req, xsel, aer}.

Test Plan:
1. Defaults, evt_ready=1: Y=0x055 then X=0x12A -> ack high at edge 7 (Y) and edge 4 (X); single evt_valid with evt_y=0x055, evt_x=0x12A; orphan_x=0.
2. Row burst: Y=0x00A, then X=0x001, 0x002, 0x003 -> three events, all evt_y=0x00A, in order.
3. After reset, X=0x3FF with no Y -> orphan_x 1-cycle pulse, ack completes normally, evt_valid stays 0.
4. Backpressure: evt_ready=0; Y=0x010, X=0x020, X=0x021 -> event 1 held stable; ack for 2nd X stays 0. Raise evt_ready -> event 1 accepted, event 2 (0x010/0x021) valid next edge, then ack rises.
5. Timeout: hold req high 100 cycles after ack -> timeout_err pulse on 64th ACK cycle; ack drops; no new capture until req low. The next Y/X pair completes normally.
6. en=0 with req pulsed -> ack stays 0 and busy stays 0. Reset asserted during ACK -> ack=0 immediately; a subsequent X gives orphan_x.

Source files
------------

// File: rtl/dvs_ravens_pkg.sv
// Shared types and default constants for the DVS/RAVENS front end.
// Clock period drives the derived AER setup delay.
package dvs_ravens_pkg;

   localparam int CLK_PERIOD_NS = 10;
   localparam int AER_T_SETUP_NS = 50;

   localparam int AER_ADDR_W = 10;
   localparam int AER_SYNC_STAGES = 2;
   localparam int AER_SETUP_RAW =
      AER_T_SETUP_NS / CLK_PERIOD_NS - 2;
   localparam int AER_SETUP_Y =
      (AER_SETUP_RAW > 0) ? AER_SETUP_RAW : 0;
   localparam int AER_SETUP_X = 0;
   localparam int AER_TIMEOUT = 64;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      CAPTURE,
      ACK,
      RECOVER
   } aer_rx_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dvs_sync_bus.sv
// Multi-flop synchronizer for a bundle of asynchronous inputs.
// All bits share one chain of STAGES async-reset flops.
module dvs_sync_bus #(
   parameter int WIDTH = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] ff [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '{default: '0};
      end else begin
         ff[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            ff[i] <= ff[i-1];
         end
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/dvs_aer_event_rx.sv
// DVS AER receiver: 4-phase REQ/ACK handshake, Y/X word pairing
// into events, one-entry valid/ready output with camera stall.
module dvs_aer_event_rx
   import dvs_ravens_pkg::*;
#(
   parameter int ADDR_W = AER_ADDR_W,
   parameter int SYNC_STAGES = AER_SYNC_STAGES,
   parameter int SETUP_Y = AER_SETUP_Y,
   parameter int SETUP_X = AER_SETUP_X,
   parameter int TIMEOUT = AER_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ADDR_W-1:0] aer,
   input  logic              xsel,
   input  logic              req,
   output logic              ack,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [ADDR_W-1:0] evt_y,
   output logic [ADDR_W-1:0] evt_x,
   output logic              orphan_x,
   output logic              timeout_err,
   output logic              busy
);

   localparam int SMAX = max2(SETUP_Y, SETUP_X);
   localparam int CW = max2(1, $clog2(SMAX + 1));
   localparam int TW = max2(1, $clog2(TIMEOUT + 1));

   localparam logic [CW-1:0] SY_M1 =
      CW'((SETUP_Y > 0) ? SETUP_Y - 1 : 0);
   localparam logic [CW-1:0] SX_M1 =
      CW'((SETUP_X > 0) ? SETUP_X - 1 : 0);
   localparam logic [TW-1:0] T_M1 =
      TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [ADDR_W+1:0] sync_q;
   logic [ADDR_W-1:0] aer_s;
   logic              xsel_s;
   logic              req_s;

   dvs_sync_bus #(
      .WIDTH  (ADDR_W + 2),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({req, xsel, aer}),
      .q     (sync_q)
   );

   assign {req_s, xsel_s, aer_s} = sync_q;

   aer_rx_state_t     state, state_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic [TW-1:0]     tcnt, tcnt_d;
   logic [ADDR_W-1:0] y_reg, y_reg_d;
   logic              y_valid, y_valid_d;
   logic [ADDR_W-1:0] evt_y_d, evt_x_d;
   logic              evt_valid_d;
   logic              orphan_d;
   logic              tout_d;
   logic              slot_free;

   assign slot_free = !evt_valid || evt_ready;

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      tcnt_d      = tcnt;
      y_reg_d     = y_reg;
      y_valid_d   = y_valid;
      evt_y_d     = evt_y;
      evt_x_d     = evt_x;
      evt_valid_d = evt_valid && !evt_ready;
      orphan_d    = 1'b0;
      tout_d      = 1'b0;
      unique case (state)
         IDLE: begin
            if (en && req_s) begin
               if (xsel_s) begin
                  if (SETUP_X == 0) begin
                     state_d = CAPTURE;
                  end else begin
                     state_d = SETUP;
                     cnt_d   = SX_M1;
                  end
               end else begin
                  if (SETUP_Y == 0) begin
                     state_d = CAPTURE;
                  end else begin
                     state_d = SETUP;
                     cnt_d   = SY_M1;
                  end
               end
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         CAPTURE: begin
            if (!xsel_s) begin
               y_reg_d   = aer_s;
               y_valid_d = 1'b1;
               state_d   = ACK;
            end else if (!y_valid) begin
               orphan_d = 1'b1;
               state_d  = ACK;
            end else if (slot_free) begin
               evt_y_d     = y_reg;
               evt_x_d     = aer_s;
               evt_valid_d = 1'b1;
               state_d     = ACK;
            end
            if (state_d == ACK) begin
               tcnt_d = '0;
            end
         end
         ACK: begin
            if (!req_s) begin
               state_d = IDLE;
            end else if (TIMEOUT > 0 && tcnt == T_M1) begin
               tout_d  = 1'b1;
               state_d = RECOVER;
            end else begin
               tcnt_d = tcnt + 1'b1;
            end
         end
         RECOVER: begin
            if (!req_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ack mirrors the registered ACK state so it can never glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         tcnt        <= '0;
         y_reg       <= '0;
         y_valid     <= 1'b0;
         evt_y       <= '0;
         evt_x       <= '0;
         evt_valid   <= 1'b0;
         orphan_x    <= 1'b0;
         timeout_err <= 1'b0;
         ack         <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         tcnt        <= tcnt_d;
         y_reg       <= y_reg_d;
         y_valid     <= y_valid_d;
         evt_y       <= evt_y_d;
         evt_x       <= evt_x_d;
         evt_valid   <= evt_valid_d;
         orphan_x    <= orphan_d;
         timeout_err <= tout_d;
         ack         <= (state_d == ACK);
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_dvs_aer_event_rx.sv
// Self-checking bench for dvs_aer_event_rx with a camera model
// and an event scoreboard.
module tb_dvs_aer_event_rx;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b1;
   logic [AW-1:0] aer = '0;
   logic          xsel = 1'b0;
   logic          req = 1'b0;
   logic          evt_ready = 1'b1;
   logic          ack;
   logic          evt_valid;
   logic [AW-1:0] evt_y;
   logic [AW-1:0] evt_x;
   logic          orphan_x;
   logic          timeout_err;
   logic          busy;

   dvs_aer_event_rx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .aer         (aer),
      .xsel        (xsel),
      .req         (req),
      .ack         (ack),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_y       (evt_y),
      .evt_x       (evt_x),
      .orphan_x    (orphan_x),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int orphan_seen = 0;
   int orphan_exp = 0;
   int tout_seen = 0;
   int evt_seen = 0;
   logic [2*AW-1:0] sb_q[$];
   logic [2*AW-1:0] sb_e;
   bit m_yv = 1'b0;
   logic [AW-1:0] m_y = '0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (orphan_x) orphan_seen++;
      if (timeout_err) tout_seen++;
      if (evt_valid && evt_ready) begin
         check("sb_nonempty", 32'(sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            sb_e = sb_q.pop_front();
            check("evt_y", 32'(evt_y), 32'(sb_e[2*AW-1:AW]));
            check("evt_x", 32'(evt_x), 32'(sb_e[AW-1:0]));
            evt_seen++;
         end
      end
   end

   task automatic wait_ack(input logic v, output int cyc);
      cyc = 0;
      while (ack !== v && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (ack !== v) check("ack_wait", 32'(ack), 32'(v));
   endtask

   task automatic start_word(input logic x, input logic [AW-1:0] a);
      @(posedge clk);
      #1;
      aer  = a;
      xsel = x;
      req  = 1'b1;
      if (!x) begin
         m_yv = 1'b1;
         m_y  = a;
      end else if (m_yv) begin
         sb_q.push_back({m_y, a});
      end else begin
         orphan_exp++;
      end
   endtask

   task automatic finish_word();
      int c;
      req = 1'b0;
      wait_ack(1'b0, c);
   endtask

   task automatic send_word(input logic x, input logic [AW-1:0] a,
                            input int lat);
      int c;
      start_word(x, a);
      wait_ack(1'b1, c);
      if (lat >= 0) check(x ? "lat_x" : "lat_y", c, lat);
      finish_word();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_yv = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      bit seen;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", ack, 0);
      check("rst_evt_valid", evt_valid, 0);
      check("rst_evt_y", evt_y, 0);
      check("rst_evt_x", evt_x, 0);
      check("rst_orphan", orphan_x, 0);
      check("rst_tout", timeout_err, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;

      send_word(1'b0, 10'h055, 7);
      send_word(1'b1, 10'h12A, 4);
      repeat (3) @(posedge clk);
      #1;
      check("t1_events", evt_seen, 1);
      check("t1_orphan", orphan_seen, 0);
      check("t1_valid_clr", evt_valid, 0);

      send_word(1'b0, 10'h00A, -1);
      for (int i = 1; i <= 3; i++) begin
         send_word(1'b1, AW'(i), -1);
      end
      repeat (3) @(posedge clk);
      #1;
      check("t2_events", evt_seen, 4);

      do_reset();
      send_word(1'b1, 10'h3FF, 4);
      repeat (3) @(posedge clk);
      #1;
      check("t3_orphan", orphan_seen, 1);
      check("t3_valid", evt_valid, 0);

      evt_ready = 1'b0;
      send_word(1'b0, 10'h010, -1);
      send_word(1'b1, 10'h020, 4);
      start_word(1'b1, 10'h021);
      repeat (20) @(posedge clk);
      #1;
      check("t4_stall_ack", ack, 0);
      check("t4_hold_valid", evt_valid, 1);
      check("t4_hold_y", evt_y, 10'h010);
      check("t4_hold_x", evt_x, 10'h020);
      check("t4_busy", busy, 1);
      evt_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t4_ev2_valid", evt_valid, 1);
      check("t4_ev2_x", evt_x, 10'h021);
      check("t4_ev2_ack", ack, 1);
      finish_word();
      repeat (3) @(posedge clk);
      #1;
      check("t4_events", evt_seen, 6);

      start_word(1'b0, 10'h0AA);
      wait_ack(1'b1, c);
      c = 0;
      while (ack === 1'b1 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("t5_ack_cycles", c, 64);
      check("t5_tout_pulse", timeout_err, 1);
      repeat (35) @(posedge clk);
      #1;
      check("t5_recover_ack", ack, 0);
      check("t5_recover_busy", busy, 1);
      req = 1'b0;
      c = 0;
      while (busy === 1'b1 && c < 50) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("t5_idle", busy, 0);
      check("t5_tout_cnt", tout_seen, 1);
      send_word(1'b0, 10'h0BB, 7);
      send_word(1'b1, 10'h0CC, 4);
      repeat (3) @(posedge clk);
      #1;
      check("t5_events", evt_seen, 7);

      en = 1'b0;
      @(posedge clk);
      #1;
      aer  = 10'h066;
      xsel = 1'b0;
      req  = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (ack || busy) seen = 1'b1;
      end
      check("t6_en_off", seen, 0);
      req = 1'b0;
      repeat (5) @(posedge clk);
      en = 1'b1;

      start_word(1'b0, 10'h077);
      wait_ack(1'b1, c);
      rst_n = 1'b0;
      #1;
      check("t6_rst_ack", ack, 0);
      check("t6_rst_busy", busy, 0);
      req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_yv = 1'b0;
      send_word(1'b1, 10'h155, 4);
      repeat (3) @(posedge clk);
      #1;
      check("t6_orphan", orphan_seen, orphan_exp);
      check("t6_valid", evt_valid, 0);
      check("sb_drained", sb_q.size(), 0);
      check("tout_total", tout_seen, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
